// File: rtl/md_unit.sv
// rtl/md_unit.sv - multiply/divide unit owning HI/LO; MDU_MADD_EN adds madd/maddu/msub/msubu
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  MD_OP,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        E_START,
   output logic        E_BUSY,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

   logic [3:0]  cnt;
   logic [31:0] phi;
   logic [31:0] plo;
   logic [63:0] hilo;
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [63:0] result;
   logic        div_ovf;
   logic [31:0] div_s_b;
   logic [31:0] div_u_b;
   logic [31:0] quo_s;
   logic [31:0] rem_s;
   logic [31:0] quo_u;
   logic [31:0] rem_u;
   logic        is_multi;
   logic        is_div;

   assign hilo   = {HI, LO};
   assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign prod_u = {32'd0, A} * {32'd0, B};

   // Zero divisors and the one overflowing signed quotient are steered to a
   // divide-by-one so the divider never sees an undefined case; the zero
   // divisor result is discarded below in favour of the current HI/LO.
   assign div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
   assign div_s_b = ((B == 32'd0) || div_ovf) ? 32'd1 : B;
   assign div_u_b = (B == 32'd0) ? 32'd1 : B;
   assign quo_s   = $signed(A) / $signed(div_s_b);
   assign rem_s   = $signed(A) % $signed(div_s_b);
   assign quo_u   = A / div_u_b;
   assign rem_u   = A % div_u_b;

   // Decode the E-stage op and form the pending {HI,LO} result
   always_comb begin
      is_multi = 1'b0;
      is_div   = 1'b0;
      result   = hilo;
      case (MD_OP)
         OP_MULT: begin
            is_multi = 1'b1;
            result   = prod_s;
         end
         OP_MULTU: begin
            is_multi = 1'b1;
            result   = prod_u;
         end
         OP_DIV: begin
            is_multi = 1'b1;
            is_div   = 1'b1;
            result   = (B == 32'd0) ? hilo : {rem_s, quo_s};
         end
         OP_DIVU: begin
            is_multi = 1'b1;
            is_div   = 1'b1;
            result   = (B == 32'd0) ? hilo : {rem_u, quo_u};
         end
`ifdef MDU_MADD_EN
         OP_MADD: begin
            is_multi = 1'b1;
            result   = hilo + prod_s;
         end
         OP_MADDU: begin
            is_multi = 1'b1;
            result   = hilo + prod_u;
         end
         OP_MSUB: begin
            is_multi = 1'b1;
            result   = hilo - prod_s;
         end
         OP_MSUBU: begin
            is_multi = 1'b1;
            result   = hilo - prod_u;
         end
`endif
         default: ;
      endcase
   end

   assign E_BUSY  = (cnt != 4'd0);
   assign E_START = is_multi && !E_BUSY;

   // Latency counter, pending result capture, commit on the last busy cycle, mthi/mtlo when idle
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= 4'd0;
         phi <= 32'd0;
         plo <= 32'd0;
         HI  <= 32'd0;
         LO  <= 32'd0;
      end else if (cnt != 4'd0) begin
         cnt <= cnt - 4'd1;
         if (cnt == 4'd1) begin
            HI <= phi;
            LO <= plo;
         end
      end else if (E_START) begin
         phi <= result[63:32];
         plo <= result[31:0];
         cnt <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
      end else if (MD_OP == OP_MTHI) begin
         HI <= A;
      end else if (MD_OP == OP_MTLO) begin
         LO <= A;
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - randomized self-checking bench for md_unit against a timeline model
module tb_md_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  MD_OP;
   logic [31:0] A;
   logic [31:0] B;
   logic        E_START;
   logic        E_BUSY;
   logic [31:0] HI;
   logic [31:0] LO;

   int checks = 0;
   int errors = 0;

   // reference state: architectural HI/LO, last busy cycle, commit cycle and value
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   logic [63:0] pend = 64'd0;
   int          cyc = 0;
   int          busy_end = -1;
   int          commit_cyc = -1;

   md_unit dut (
      .clk    (clk),
      .reset  (reset),
      .MD_OP  (MD_OP),
      .A      (A),
      .B      (B),
      .E_START(E_START),
      .E_BUSY (E_BUSY),
      .HI     (HI),
      .LO     (LO)
   );

   // 100 MHz pipeline clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic bit is_multi(input logic [3:0] op);
`ifdef MDU_MADD_EN
      return (op >= 4'd1 && op <= 4'd4) || (op >= 4'd7 && op <= 4'd10);
`else
      return (op >= 4'd1 && op <= 4'd4);
`endif
   endfunction

   function automatic int latency(input logic [3:0] op);
      return (op == 4'd3 || op == 4'd4) ? 10 : 5;
   endfunction

   function automatic logic [63:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                                input logic [31:0] b, input logic [63:0] hl);
      longint      sa, sb, q, r;
      logic [63:0] ua, ub, ps, pu, uq, ur;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      ps = 64'(sa * sb);
      pu = ua * ub;
      case (op)
         4'd1: return ps;
         4'd2: return pu;
         4'd3: begin
            if (b == 32'd0) return hl;
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         4'd4: begin
            if (b == 32'd0) return hl;
            uq = ua / ub;
            ur = ua % ub;
            return {ur[31:0], uq[31:0]};
         end
         4'd7:  return hl + ps;
         4'd8:  return hl + pu;
         4'd9:  return hl - ps;
         4'd10: return hl - pu;
         default: return hl;
      endcase
   endfunction

   task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic rst, input bit chk);
      bit busy;
      bit start;
      @(negedge clk);
      reset = rst;
      MD_OP = op;
      A     = a;
      B     = b;
      if (cyc == commit_cyc) begin
         {m_hi, m_lo} = pend;
         commit_cyc = -1;
      end
      busy  = (cyc <= busy_end);
      start = is_multi(op) && !busy;
      #1;
      if (chk) begin
         check("e_busy", 64'(E_BUSY), 64'(busy));
         check("e_start", 64'(E_START), 64'(start));
         check("hi", 64'(HI), 64'(m_hi));
         check("lo", 64'(LO), 64'(m_lo));
      end
      if (rst) begin
         m_hi = 32'd0;
         m_lo = 32'd0;
         busy_end = -1;
         commit_cyc = -1;
      end else if (!busy) begin
         if (start) begin
            pend = model_result(op, a, b, {m_hi, m_lo});
            busy_end = cyc + latency(op);
            commit_cyc = busy_end + 1;
         end else if (op == 4'd5) begin
            m_hi = a;
         end else if (op == 4'd6) begin
            m_lo = a;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h8000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'd0;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      reset = 1'b1;
      MD_OP = 4'd0;
      A     = 32'd0;
      B     = 32'd0;

      step(4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      step(4'd0, 32'd0, 32'd0, 1'b1, 1'b1);
      check("rst_busy", 64'(E_BUSY), 64'd0);
      check("rst_hilo", {HI, LO}, 64'd0);

      // signed multiply: -1 * 2
      step(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
      idle(5);
      check("mult_hi", 64'(HI), 64'hFFFF_FFFF);
      check("mult_lo", 64'(LO), 64'hFFFF_FFFE);

      // unsigned multiply, HI/LO hold old values while busy
      step(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
      idle(2);
      check("multu_hold_hi", 64'(HI), 64'hFFFF_FFFF);
      idle(3);
      check("multu_hi", 64'(HI), 64'h1);
      check("multu_lo", 64'(LO), 64'hFFFF_FFFE);

      // signed divide -7 / 2
      step(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
      idle(10);
      check("div_lo", 64'(LO), 64'hFFFF_FFFD);
      check("div_hi", 64'(HI), 64'hFFFF_FFFF);

      // unsigned divide by zero keeps HI/LO
      step(4'd4, 32'h1234, 32'd0, 1'b0, 1'b1);
      idle(10);
      check("divu0_hilo", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);

      // overflowing signed divide
      step(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
      idle(10);
      check("div_ovf", {HI, LO}, 64'h0000_0000_8000_0000);

      // mthi ignored while busy, accepted the cycle busy falls
      step(4'd3, 32'd100, 32'd7, 1'b0, 1'b1);
      idle(4);
      step(4'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b1);
      idle(5);
      check("mthi_busy_ignored", {HI, LO}, {32'd2, 32'd14});
      step(4'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b1);
      check("mthi_at_fall", {HI, LO}, {32'h1234_5678, 32'd14});

      // reset at busy cycle 3 of a divide aborts it
      step(4'd3, 32'd1000, 32'd3, 1'b0, 1'b1);
      idle(2);
      step(4'd0, 32'd0, 32'd0, 1'b1, 1'b1);
      check("rst_mid_busy", 64'(E_BUSY), 64'd0);
      check("rst_mid_hilo", {HI, LO}, 64'd0);
      idle(12);
      check("rst_no_commit", {HI, LO}, 64'd0);

      // maddu 1*1 onto {0, 0xFFFFFFFF}
      step(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
      step(4'd5, 32'd0, 32'd0, 1'b0, 1'b1);
      step(4'd8, 32'd1, 32'd1, 1'b0, 1'b1);
      idle(5);
`ifdef MDU_MADD_EN
      check("maddu", {HI, LO}, 64'h0000_0001_0000_0000);
`else
      check("maddu_off", {HI, LO}, 64'h0000_0000_FFFF_FFFF);
`endif

      // randomized traffic, including ops while busy and stray resets
      for (int i = 0; i < 3000; i++) begin
         logic [3:0] op;
         op = 4'($urandom_range(0, 15));
         step(op, pick_operand(), pick_operand(), ($urandom_range(0, 63) == 0), 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit in the E stage of the five-stage pipeline. It owns the HI/LO registers, runs multi-cycle mult/div operations, and drives `E_START`/`E_BUSY` into the main controller's stall logic. The controller holds any HI/LO-touching instruction in D while a multiply or divide is in flight. Results commit to HI/LO only at the end of the operation's latency, matching the pipeline's stall model.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for multiply-class ops.
- `DIV_CYCLES`, default 10: busy cycles for divide ops.

Ports:
- `clk` input 1: pipeline clock. One clock only.
- `reset` input 1: synchronous, active-high.
- `MD_OP` input 4: E-stage operation.
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo.
  - 7 madd, 8 maddu, 9 msub, 10 msubu (only with `MDU_MADD_EN`).
  - 11–15 reserved, treated as none.
- `A` input 32: rs operand after E-stage forwarding.
- `B` input 32: rt operand after E-stage forwarding.
- `E_START` output 1: combinational; high when `MD_OP` is a multi-cycle op and `E_BUSY`=0.
- `E_BUSY` output 1: registered; high while an operation is in flight.
- `HI` output 32: architectural HI register.
- `LO` output 32: architectural LO register.

## Operation
- State: `cnt` (4 bits), pending result `phi`/`plo`, committed `HI`/`LO`.
- `E_BUSY` = (`cnt` != 0).
- **Idle** (`cnt`==0), multi-cycle op accepted (`E_START`=1):
  - compute result into `phi`/`plo`;
  - load `cnt` with `MULT_CYCLES` (mult/madd class) or `DIV_CYCLES` (div/divu).
- **Busy** (`cnt`!=0):
  - decrement `cnt` each cycle;
  - on the cycle `cnt`==1, write `HI`<=`phi` and `LO`<=`plo`.
- `mthi`/`mtlo` while idle: write `A` to `HI`/`LO` at the next edge; `E_BUSY` is unaffected.
- Any op while busy is ignored, including `mthi`/`mtlo`. The controller guarantees this never occurs, and the unit does not rely on that guarantee.
- Arithmetic:
  - mult: signed 32×32 to 64 bits, {HI,LO}. multu: unsigned.
  - div: signed; LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend. divu: unsigned.
  - Divide by zero: `phi`/`plo` are loaded with the current `HI`/`LO`, so the commit leaves them unchanged. Full `DIV_CYCLES` busy period still runs.
  - 0x80000000 / 0xFFFFFFFF signed: LO=0x80000000, HI=0.
- Reset: `cnt`=0, `E_BUSY`=0, `HI`=`LO`=`phi`=`plo`=0. Reset mid-operation aborts it; no commit occurs.

## Timing
- Op presented in cycle t, `E_START`=1 in cycle t.
- `E_BUSY`=1 in cycles t+1 … t+N, where N = `MULT_CYCLES` or `DIV_CYCLES`.
- New `HI`/`LO` are visible in cycle t+N+1, the same cycle `E_BUSY` falls.
- A new op is accepted in cycle t+N+1; back-to-back operations have zero idle gap.
- `mthi`/`mtlo` in cycle t: new value is visible at t+1.
- `HI`/`LO` hold their old values throughout the busy period.
- Reset asserted in any cycle: all state is at reset values in the following cycle; `E_START` follows `MD_OP` immediately after reset.

## Configuration
- `MDU_MADD_EN` defined:
  - ops 7–10 accepted with `MULT_CYCLES` latency;
  - pending = {HI,LO} ± product, 64-bit wrap-around, signed product for madd/msub, unsigned for maddu/msubu;
  - {HI,LO} is sampled at acceptance.
- `MDU_MADD_EN` undefined: ops 7–10 behave as none; `E_START`=0 and no state changes.

## Test plan
- Reset, then mult with A=0xFFFFFFFF, B=2:
  - `E_START`=1 at t; `E_BUSY` high for cycles t+1..t+5;
  - HI=0xFFFFFFFF, LO=0xFFFFFFFE at t+6.
- multu with same operands → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles. HI/LO sampled during busy show the previous values.
- div A=0xFFFFFFF9 (−7), B=2 → 10 busy cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with B=0 → HI/LO unchanged after 10 busy cycles.
- Simultaneous and mid-operation events:
  - mthi A=0x12345678 while busy → ignored;
  - mthi issued the cycle `E_BUSY` falls → HI=0x12345678 next cycle;
  - reset at busy cycle 3 of a div → `E_BUSY`=0, HI=LO=0, no late commit.
- `MDU_MADD_EN` build: HI=0, LO=0xFFFFFFFF, then maddu A=1, B=1 → HI=1, LO=0. Non-`MDU_MADD_EN` build: same op gives `E_START`=0 and HI/LO unchanged.
